// File: rtl/data_mem_responder.sv
// Fixed-latency data memory slave: 128 x 32-bit little-endian words, RISC-V
// byte/half/word loads and stores, one-cycle ready pulse with a coincident fault flag.
module data_mem_responder #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [8:0]  addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ready,
  output logic        fault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        lat_rd, lat_wr;
  logic [8:0]  lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wr_data;
  logic [31:0] mem [0:127];

  // While accepting in IDLE the live inputs are the operands; afterwards the
  // latched copy is. This lets WAIT_STATES=0 complete straight from IDLE.
  logic        op_rd, op_wr;
  logic [8:0]  op_addr;
  logic [2:0]  op_funct3;
  assign op_rd     = (state == IDLE) ? rd     : lat_rd;
  assign op_wr     = (state == IDLE) ? wr     : lat_wr;
  assign op_addr   = (state == IDLE) ? addr   : lat_addr;
  assign op_funct3 = (state == IDLE) ? funct3 : lat_funct3;

  logic        op_fault;
  logic [31:0] ld_word, ld_value;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ld_word  = mem[op_addr[8:2]];
    ld_byte  = ld_word[{op_addr[1:0], 3'b000} +: 8];
    ld_half  = op_addr[1] ? ld_word[31:16] : ld_word[15:0];
    op_fault = 1'b0;
    ld_value = 32'h0;
    if (op_rd && op_wr) begin
      op_fault = 1'b1;
    end else if (op_rd) begin
      case (op_funct3)
        3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
        3'b001:  begin op_fault = op_addr[0];   ld_value = {{16{ld_half[15]}}, ld_half}; end
        3'b010:  begin op_fault = |op_addr[1:0]; ld_value = ld_word; end
        3'b100:  ld_value = {24'h0, ld_byte};
        3'b101:  begin op_fault = op_addr[0];   ld_value = {16'h0, ld_half}; end
        default: op_fault = 1'b1;
      endcase
    end else begin
      case (op_funct3)
        3'b000:  op_fault = 1'b0;
        3'b001:  op_fault = op_addr[0];
        3'b010:  op_fault = |op_addr[1:0];
        default: op_fault = 1'b1;
      endcase
    end
  end

  logic [3:0]  st_be;
  logic [31:0] st_data;
  always_comb begin
    st_be   = 4'b0000;
    st_data = lat_wr_data;
    case (lat_funct3[1:0])
      2'b00: begin st_be = 4'b0001 << lat_addr[1:0]; st_data = {4{lat_wr_data[7:0]}}; end
      2'b01: begin st_be = lat_addr[1] ? 4'b1100 : 4'b0011; st_data = {2{lat_wr_data[15:0]}}; end
      2'b10: st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  logic finish;
  assign finish = ((state == IDLE) && (rd || wr) && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (cnt == 4'd1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b0;
      fault   <= 1'b0;
      rd_data <= 32'h0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: if (rd || wr) begin
          lat_rd      <= rd;
          lat_wr      <= wr;
          lat_addr    <= addr;
          lat_funct3  <= funct3;
          lat_wr_data <= wr_data;
          cnt         <= 4'(WAIT_STATES);
          state       <= (WAIT_STATES == 0) ? DONE : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish) begin
        ready <= 1'b1;
        fault <= op_fault;
        if (op_fault)   rd_data <= 32'h0;
        else if (op_rd) rd_data <= ld_value;
      end
    end
  end

  // NOTE: the memory array has no reset; contents survive reset and it maps onto plain RAM.
  // The store commits on the edge leaving DONE, where the registered fault already covers rd&wr.
  always_ff @(posedge clk) begin
    if (!reset && (state == DONE) && lat_wr && !fault) begin
      for (int i = 0; i < 4; i++)
        if (st_be[i]) mem[lat_addr[8:2]][8*i +: 8] <= st_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized accesses
// checked against a byte-array memory model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance with WAIT_STATES=1
  logic        rd_a, wr_a, ready_a, fault_a;
  logic [8:0]  addr_a;
  logic [2:0]  funct3_a;
  logic [31:0] wr_data_a, rd_data_a;
  // Instance with WAIT_STATES=0
  logic        rd_b, wr_b, ready_b, fault_b;
  logic [8:0]  addr_b;
  logic [2:0]  funct3_b;
  logic [31:0] wr_data_b, rd_data_b;

  data_mem_responder #(.WAIT_STATES(1)) dut_a (
    .clk(clk), .reset(reset), .rd(rd_a), .wr(wr_a), .addr(addr_a), .funct3(funct3_a),
    .wr_data(wr_data_a), .rd_data(rd_data_a), .ready(ready_a), .fault(fault_a));

  data_mem_responder #(.WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .rd(rd_b), .wr(wr_b), .addr(addr_b), .funct3(funct3_b),
    .wr_data(wr_data_b), .rd_data(rd_data_b), .ready(ready_b), .fault(fault_b));

  int tests = 0;
  int fails = 0;

  logic [7:0]  mm [0:511];
  logic [31:0] exp_rd;
  logic [31:0] got_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f);
    return 1 << (f % 4);
  endfunction

  function automatic bit model_fault(input logic r, input logic w, input logic [8:0] a,
                                     input logic [2:0] f);
    if (r && w) return 1'b1;
    if (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (w && f > 3'd2) return 1'b1;
    return (int'(a) % acc_size(f)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
    int sz = acc_size(f);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v |= {24'h0, mm[int'(a) + i]} << (8 * i);
    if (f < 3'd4 && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 32'd1);
    return v;
  endfunction

  // One access on the WAIT_STATES=1 instance; called just after a falling edge.
  task automatic do_acc(input logic r, input logic w, input logic [8:0] a,
                        input logic [2:0] f, input logic [31:0] d, input string tag);
    logic        flt;
    logic [31:0] exp;
    int          n;
    flt = model_fault(r, w, a, f);
    if (flt)    exp = 32'h0;
    else if (r) exp = model_load(a, f);
    else        exp = exp_rd;
    rd_a = r; wr_a = w; addr_a = a; funct3_a = f; wr_data_a = d;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      addr_a = 9'($urandom); funct3_a = 3'($urandom); wr_data_a = $urandom;
      if (!ready_a && n == 1) check({tag, " fault_low_while_waiting"}, {31'h0, fault_a}, 32'h0);
    end while (!ready_a && n < 20);
    check({tag, " latency"}, n, 32'd2);
    check({tag, " fault"}, {31'h0, fault_a}, {31'h0, flt});
    check({tag, " rd_data"}, rd_data_a, exp);
    got_rd = rd_data_a;
    rd_a = 1'b0; wr_a = 1'b0;
    if (!flt && w)
      for (int i = 0; i < acc_size(f); i++) mm[int'(a) + i] = d[8*i +: 8];
    exp_rd = exp;
    @(posedge clk); @(negedge clk);
    check({tag, " ready_single_pulse"}, {31'h0, ready_a}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mm[i] = 8'h00;
    exp_rd = 32'h0;
    reset = 1'b1;
    rd_a = 0; wr_a = 0; addr_a = 0; funct3_a = 0; wr_data_a = 0;
    rd_b = 0; wr_b = 0; addr_b = 0; funct3_b = 0; wr_data_b = 0;
    repeat (2) @(negedge clk);
    check("reset ready", {31'h0, ready_a}, 32'h0);
    check("reset fault", {31'h0, fault_a}, 32'h0);
    check("reset rd_data", rd_data_a, 32'h0);
    check("reset rd_data ws0", rd_data_b, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed scenarios
    do_acc(0, 1, 9'h010, 3'b010, 32'hDEADBEEF, "sw 010");
    do_acc(1, 0, 9'h010, 3'b010, 32'h0, "lw 010");
    check("lw 010 literal", got_rd, 32'hDEADBEEF);
    do_acc(0, 1, 9'h011, 3'b000, 32'h00000080, "sb 011");
    check("sb keeps rd_data", got_rd, 32'hDEADBEEF);
    do_acc(1, 0, 9'h011, 3'b000, 32'h0, "lb 011");
    check("lb 011 literal", got_rd, 32'hFFFFFF80);
    do_acc(1, 0, 9'h011, 3'b100, 32'h0, "lbu 011");
    check("lbu 011 literal", got_rd, 32'h00000080);
    do_acc(1, 0, 9'h010, 3'b010, 32'h0, "lw 010b");
    check("lw 010b literal", got_rd, 32'hDEAD80EF);
    do_acc(1, 0, 9'h012, 3'b101, 32'h0, "lhu 012");
    check("lhu 012 literal", got_rd, 32'h0000DEAD);
    do_acc(1, 0, 9'h013, 3'b001, 32'h0, "lh 013 misaligned");
    do_acc(0, 1, 9'h012, 3'b010, 32'h0, "sw 012 misaligned");
    do_acc(1, 1, 9'h010, 3'b010, 32'h55555555, "rd+wr");
    do_acc(1, 0, 9'h010, 3'b011, 32'h0, "ld funct3 011");
    do_acc(0, 1, 9'h010, 3'b110, 32'h0, "st funct3 110");
    do_acc(1, 0, 9'h010, 3'b010, 32'h0, "lw 010c");
    check("lw 010c literal", got_rd, 32'hDEAD80EF);

    // Reset while the store is in WAIT aborts it
    do_acc(0, 1, 9'h020, 3'b010, 32'h11111111, "sw 020");
    wr_a = 1'b1; addr_a = 9'h020; funct3_a = 3'b010; wr_data_a = 32'h12345678;
    @(posedge clk); @(negedge clk);
    reset = 1'b1; wr_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      check("abort no ready", {31'h0, ready_a}, 32'h0);
    end
    check("abort rd_data", rd_data_a, 32'h0);
    exp_rd = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    do_acc(1, 0, 9'h020, 3'b010, 32'h0, "lw 020 after abort");
    check("lw 020 literal", got_rd, 32'h11111111);

    // Back-to-back stores with WAIT_STATES=0 and wr held high
    wr_b = 1'b1; addr_b = 9'h1FC; funct3_b = 3'b010; wr_data_b = 32'hCAFEF00D;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("ws0 ready A+%0d", k), {31'h0, ready_b}, {31'h0, (k % 2) == 1});
      if (k == 5) wr_b = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    check("ws0 ready A+6", {31'h0, ready_b}, 32'h0);
    rd_b = 1'b1;
    @(posedge clk); @(negedge clk);
    rd_b = 1'b0;
    check("ws0 lw ready", {31'h0, ready_b}, 32'h1);
    check("ws0 lw fault", {31'h0, fault_b}, 32'h0);
    check("ws0 lw data", rd_data_b, 32'hCAFEF00D);

    // Preload a region, then random traffic restricted to it
    for (int i = 0; i < 17; i++)
      do_acc(0, 1, (i == 16) ? 9'h1FC : 9'(i * 4), 3'b010, $urandom, "preload");
    for (int t = 0; t < 60; t++) begin
      int          k = $urandom_range(0, 9);
      int          idx = $urandom_range(0, 16);
      logic [8:0]  a;
      a = ((idx == 16) ? 9'h1FC : 9'(idx * 4)) + 9'($urandom_range(0, 3));
      do_acc(k < 5, (k >= 5), a, 3'($urandom_range(0, 7)), $urandom,
             $sformatf("rand%0d", t));
      if (k == 9) do_acc(1, 1, a, 3'($urandom_range(0, 7)), $urandom, "rand both");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WAIT_STATES SHALL be: default 1, range 0..15; it sets the number of stall cycles between request acceptance and completion.
REQ-002 Ports SHALL be exactly:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rd  input  1  load request from core.
- wr  input  1  store request from core.
- addr  input  9  byte address (512-byte space).
- funct3  input  3  RISC-V load/store size/sign code.
- wr_data  input  32  store data, right-aligned.
- rd_data  output  32  registered load result.
- ready  output  1  one-cycle completion pulse.
- fault  output  1  one-cycle error flag, coincident with ready.
REQ-003 Storage SHALL be 128 x 32-bit words, little-endian; word index = addr[8:2], byte lane = addr[1:0].

Function
REQ-004 FSM states SHALL be IDLE, WAIT, DONE.
REQ-005 IDLE: a request (rd=1 or wr=1) SHALL be accepted in that cycle (cycle A); addr, funct3, wr_data, rd and wr SHALL be latched; the wait counter SHALL be loaded with WAIT_STATES.
REQ-006 IDLE -> WAIT if WAIT_STATES>0; IDLE -> DONE if WAIT_STATES=0.
REQ-007 WAIT: decrement the counter each cycle; go to DONE when the counter reaches 1.
REQ-008 ready SHALL be high for exactly one cycle, cycle A+WAIT_STATES+1, which is the cycle the FSM is in DONE; DONE -> IDLE unconditionally.
REQ-009 Input changes after acceptance SHALL be ignored; only latched values are used.
REQ-010 The requester drops rd/wr on the edge ending the ready cycle; a request still high in IDLE SHALL be accepted as a new request.
REQ-011 Minimum request-to-request spacing SHALL be WAIT_STATES+2 cycles.
REQ-012 Store effect SHALL apply at the edge ending the ready cycle; memory SHALL be unchanged before then.
REQ-013 Store lane rules:
- SB (000): byte addr[1:0] <= wr_data[7:0].
- SH (001): halfword addr[1] <= wr_data[15:0].
- SW (010): word <= wr_data.
- Other lanes unchanged.
REQ-014 Load result SHALL be driven on rd_data during the ready cycle and held until the next completion:
- LB (000): sign-extend byte.
- LH (001): sign-extend halfword.
- LW (010): word.
- LBU (100): zero-extend byte.
- LHU (101): zero-extend halfword.
REQ-015 Fault conditions, each causing fault=1 with ready:
- LH/LHU/SH with addr[0]=1.
- LW/SW with addr[1:0]!=0.
- Undefined funct3 (load: 011/110/111; store: 011..111).
- rd=1 and wr=1 at acceptance.
REQ-016 On a faulting access, memory SHALL NOT be written and rd_data SHALL become 0x00000000.
REQ-017 On a non-faulting store, rd_data SHALL hold its previous value.
REQ-018 fault SHALL be 0 in every cycle where ready=0.
REQ-019 Addresses SHALL NOT wrap; all 9-bit values are valid, and 0x1FC..0x1FF is the last word.

Reset
REQ-020 While reset=1 at a rising edge: state <= IDLE, counter <= 0, ready <= 0, fault <= 0, rd_data <= 0.
REQ-021 Memory contents SHALL be preserved across reset.
REQ-022 Reset during WAIT or DONE SHALL abort the access: no ready pulse, no memory write.
REQ-023 No request SHALL be accepted in a cycle where reset=1.

Verification (WAIT_STATES=1 unless stated)
REQ-024 SW addr 0x010 data 0xDEADBEEF accepted in cycle A -> ready in A+2, fault=0; then LW 0x010 -> rd_data 0xDEADBEEF in its ready cycle.
REQ-025 After REQ-024: SB 0x011 data 0x00000080 -> LB 0x011 gives 0xFFFFFF80; LBU 0x011 gives 0x00000080; LW 0x010 gives 0xDEAD80EF; LHU 0x012 gives 0x0000DEAD.
REQ-026 LH 0x013 -> ready with fault=1, rd_data 0x00000000; SW 0x012 data 0x0 -> fault=1; then LW 0x010 still returns 0xDEAD80EF.
REQ-027 rd=wr=1 at addr 0x010 -> ready with fault=1 and word unchanged; funct3=011 load -> fault=1.
REQ-028 SW 0x020 data 0x11111111 completes; then SW 0x020 data 0x12345678 with reset asserted in cycle A+1 -> no ready pulse, rd_data=0; after release, LW 0x020 returns 0x11111111.
REQ-029 WAIT_STATES=0: SW 0x1FC data 0xCAFEF00D with wr held high continuously -> ready pulses in A+1, A+3, A+5; LW 0x1FC returns 0xCAFEF00D.
